// File: rtl/hamm_lane_arbiter_if.sv
// hamm_lane_arbiter_if: lane-side and corrector-side signals of the Hamming lane arbiter
interface hamm_lane_arbiter_if #(parameter int CNT_W = 8);
    logic [27:0]        in_code;
    logic [3:0]         in_valid;
    logic [3:0]         in_ready;
    logic [6:0]         out_code;
    logic [1:0]         out_lane;
    logic [2:0]         out_syn;
    logic               out_valid;
    logic               out_ready;
    logic               clr_cnt;
    logic [4*CNT_W-1:0] err_cnt;
    modport master (
        output in_code, in_valid, out_ready, clr_cnt,
        input  in_ready, out_code, out_lane, out_syn, out_valid, err_cnt
    );
    modport slave (
        input  in_code, in_valid, out_ready, clr_cnt,
        output in_ready, out_code, out_lane, out_syn, out_valid, err_cnt
    );
endinterface

// File: rtl/hamm_lane_arbiter.sv
// hamm_lane_arbiter: round-robin sharing of one Hamming(7,4) corrector among four lanes
module hamm_lane_arbiter #(
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    hamm_lane_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e           state_q, state_d;
    logic [6:0]       lane_buf_q [4];
    logic [6:0]       lane_buf_d [4];
    logic [3:0]       full_q, full_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [6:0]       code_q, code_d;
    logic [1:0]       lane_q, lane_d;
    logic [2:0]       syn_q, syn_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             gnt_any, do_grant, hs;
    logic [1:0]       gnt_lane, cand;
    logic [3:0]       load;

    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_buf_q <= '{default: '0};
            full_q     <= '0;
            ptr_q      <= 2'd3;
            code_q     <= '0;
            lane_q     <= '0;
            syn_q      <= '0;
            cnt_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            lane_buf_q <= lane_buf_d;
            full_q     <= full_d;
            ptr_q      <= ptr_d;
            code_q     <= code_d;
            lane_q     <= lane_d;
            syn_q      <= syn_d;
            cnt_q      <= cnt_d;
        end
    end

    // first full lane strictly after the last granted one
    always_comb begin
        gnt_any  = 1'b0;
        gnt_lane = ptr_q;
        cand     = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_any && full_q[cand]) begin
                gnt_any  = 1'b1;
                gnt_lane = cand;
            end
        end
    end

    always_comb begin
        state_d = (state_q == IDLE || bus.out_ready) ? (gnt_any ? BUSY : IDLE) : BUSY;
    end

    always_comb begin
        do_grant = gnt_any && (state_q == IDLE || bus.out_ready);
        hs       = (state_q == BUSY) && bus.out_ready;
        load     = bus.in_valid & ~full_q;
        full_d   = full_q;
        for (int i = 0; i < 4; i++) begin
            full_d[i]     = load[i] | (full_q[i] & ~(do_grant && gnt_lane == 2'(i)));
            lane_buf_d[i] = load[i] ? bus.in_code[7*i +: 7] : lane_buf_q[i];
            cnt_d[i]      = bus.clr_cnt ? '0 :
                            (hs && syn_q != 3'd0 && lane_q == 2'(i) && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 :
                            cnt_q[i];
        end
        ptr_d  = do_grant ? gnt_lane : ptr_q;
        code_d = do_grant ? lane_buf_q[gnt_lane] : code_q;
        lane_d = do_grant ? gnt_lane : lane_q;
        syn_d  = do_grant ? syndrome(lane_buf_q[gnt_lane]) : syn_q;
    end

    assign bus.in_ready  = ~full_q;
    assign bus.out_valid = (state_q == BUSY);
    assign bus.out_code  = code_q;
    assign bus.out_lane  = lane_q;
    assign bus.out_syn   = syn_q;

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        assign bus.err_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
    end
endmodule

// File: tb/tb_hamm_lane_arbiter.sv
// tb_hamm_lane_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_hamm_lane_arbiter;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hamm_lane_arbiter_if #(.CNT_W(CNT_W)) bus();
    hamm_lane_arbiter #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    bit         m_full [4];
    logic [6:0] m_buf  [4];
    int         m_ptr, m_lane, m_syn;
    bit         m_ov;
    logic [6:0] m_code;
    int         m_cnt  [4];

    typedef struct {
        bit          r;
        logic [3:0]  iv;
        logic [27:0] ic;
        bit          ordy;
        bit          clr;
        logic [3:0]  e_rdy;
        bit          e_ov;
        logic [6:0]  e_code;
        logic [1:0]  e_lane;
        logic [2:0]  e_syn;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // syndrome as the XOR of the 1-based positions of all set bits
    function automatic int syn_of(input logic [6:0] c);
        int s = 0;
        for (int k = 0; k < 7; k++) if (c[k]) s ^= k + 1;
        return s;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] iv, input logic [27:0] ic, input bit ordy, input bit clr);
        bit f [4];
        bit hs, found;
        int l;
        if (r) begin
            for (int i = 0; i < 4; i++) begin m_full[i] = 0; m_buf[i] = '0; m_cnt[i] = 0; end
            m_ptr = 3; m_ov = 0; m_code = '0; m_lane = 0; m_syn = 0;
            return;
        end
        f  = m_full;
        hs = m_ov && ordy;
        if (hs && m_syn != 0 && m_cnt[m_lane] < CMAX) m_cnt[m_lane]++;
        if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        if (!m_ov || ordy) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                l = (m_ptr + k) % 4;
                if (!found && f[l]) begin
                    found = 1; m_code = m_buf[l]; m_lane = l; m_syn = syn_of(m_buf[l]);
                    m_ptr = l; m_full[l] = 0;
                end
            end
            m_ov = found;
        end
        for (int i = 0; i < 4; i++) if (iv[i] && !f[i]) begin m_full[i] = 1; m_buf[i] = ic[7*i +: 7]; end
    endtask

    task automatic apply(input bit r, input logic [3:0] iv, input logic [27:0] ic, input bit ordy, input bit clr);
        logic [3:0]  e_rdy;
        logic [31:0] e_cnt;
        rst = r; bus.in_valid = iv; bus.in_code = ic; bus.out_ready = ordy; bus.clr_cnt = clr;
        @(posedge clk);
        model_step(r, iv, ic, ordy, clr);
        #1;
        for (int i = 0; i < 4; i++) begin
            e_rdy[i] = !m_full[i];
            e_cnt[8*i +: 8] = 8'(m_cnt[i]);
        end
        check("m_in_ready", 32'(bus.in_ready), 32'(e_rdy));
        check("m_out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("m_out_code", 32'(bus.out_code), 32'(m_code));
        check("m_out_lane", 32'(bus.out_lane), 32'(m_lane));
        check("m_out_syn", 32'(bus.out_syn), 32'(m_syn));
        check("m_err_cnt", bus.err_cnt, e_cnt);
    endtask

    initial begin
        logic [27:0] all4;
        logic [6:0]  h_code;
        logic [1:0]  h_lane;
        logic [2:0]  h_syn;
        int          glist [$];
        int          gcnt [4];
        bit          cleared;
        all4 = {7'h40, 7'h04, 7'h7F, 7'h00};
        tbl[0]  = '{1, 4'h0, 28'h0, 1, 0, 4'hF, 0, 7'h00, 2'd0, 3'd0, 32'h0};
        tbl[1]  = '{0, 4'h1, 28'h7F, 1, 0, 4'hE, 0, 7'h00, 2'd0, 3'd0, 32'h0};
        tbl[2]  = '{0, 4'h0, 28'h0, 1, 0, 4'hF, 1, 7'h7F, 2'd0, 3'd0, 32'h0};
        tbl[3]  = '{0, 4'h0, 28'h0, 1, 0, 4'hF, 0, 7'h7F, 2'd0, 3'd0, 32'h0};
        tbl[4]  = '{1, 4'h0, 28'h0, 1, 0, 4'hF, 0, 7'h00, 2'd0, 3'd0, 32'h0};
        tbl[5]  = '{0, 4'hF, all4, 1, 0, 4'h0, 0, 7'h00, 2'd0, 3'd0, 32'h0};
        tbl[6]  = '{0, 4'h0, 28'h0, 1, 0, 4'h1, 1, 7'h00, 2'd0, 3'd0, 32'h0};
        tbl[7]  = '{0, 4'h0, 28'h0, 1, 0, 4'h3, 1, 7'h7F, 2'd1, 3'd0, 32'h0};
        tbl[8]  = '{0, 4'h0, 28'h0, 1, 0, 4'h7, 1, 7'h04, 2'd2, 3'd3, 32'h0};
        tbl[9]  = '{0, 4'h0, 28'h0, 1, 0, 4'hF, 1, 7'h40, 2'd3, 3'd7, 32'h0001_0000};
        tbl[10] = '{0, 4'h0, 28'h0, 1, 0, 4'hF, 0, 7'h40, 2'd3, 3'd7, 32'h0101_0000};
        for (int v = 0; v < 11; v++) begin
            apply(tbl[v].r, tbl[v].iv, tbl[v].ic, tbl[v].ordy, tbl[v].clr);
            check($sformatf("tbl%0d_in_ready", v), 32'(bus.in_ready), 32'(tbl[v].e_rdy));
            check($sformatf("tbl%0d_out_valid", v), 32'(bus.out_valid), 32'(tbl[v].e_ov));
            check($sformatf("tbl%0d_out_code", v), 32'(bus.out_code), 32'(tbl[v].e_code));
            check($sformatf("tbl%0d_out_lane", v), 32'(bus.out_lane), 32'(tbl[v].e_lane));
            check($sformatf("tbl%0d_out_syn", v), 32'(bus.out_syn), 32'(tbl[v].e_syn));
            check($sformatf("tbl%0d_err_cnt", v), bus.err_cnt, tbl[v].e_cnt);
        end

        // output stall with lanes 1 and 2 full
        apply(1, 4'h0, 28'h0, 0, 0);
        apply(0, 4'h6, 28'($urandom), 0, 0);
        apply(0, 4'h6, 28'($urandom), 0, 0);
        apply(0, 4'h6, 28'($urandom), 0, 0);
        h_code = bus.out_code; h_lane = bus.out_lane; h_syn = bus.out_syn;
        check("stall_first_lane", 32'(h_lane), 32'd1);
        for (int t = 0; t < 5; t++) begin
            apply(0, 4'h6, 28'($urandom), 0, 0);
            check("stall_code", 32'(bus.out_code), 32'(h_code));
            check("stall_lane", 32'(bus.out_lane), 32'(h_lane));
            check("stall_syn", 32'(bus.out_syn), 32'(h_syn));
            check("stall_in_ready", 32'(bus.in_ready[2:1]), 32'd0);
        end
        apply(0, 4'h0, 28'h0, 1, 0);
        check("stall_drain_lane", 32'(bus.out_lane), 32'd2);
        check("stall_drain_valid", 32'(bus.out_valid), 32'd1);

        // saturation of lane 3 and clear winning over an increment
        apply(1, 4'h0, 28'h0, 1, 0);
        for (int t = 0; t < 620; t++) apply(0, 4'h8, {7'h40, 21'h0}, 1, 0);
        check("sat_cnt3", 32'(bus.err_cnt[31:24]), 32'd255);
        cleared = 0;
        for (int t = 0; t < 4 && !cleared; t++) begin
            if (m_ov) begin
                apply(0, 4'h8, {7'h40, 21'h0}, 1, 1);
                check("clr_cnt3", 32'(bus.err_cnt[31:24]), 32'd0);
                cleared = 1;
            end else apply(0, 4'h8, {7'h40, 21'h0}, 1, 0);
        end
        check("clr_reached", 32'(cleared), 32'd1);

        // fairness under continuous traffic
        apply(1, 4'h0, 28'h0, 1, 0);
        for (int t = 0; t < 44; t++) begin
            apply(0, 4'hF, 28'($urandom), 1, 0);
            if (bus.out_valid) glist.push_back(int'(bus.out_lane));
        end
        gcnt = '{0, 0, 0, 0};
        for (int j = 0; j < 40 && j < glist.size(); j++) begin
            check($sformatf("fair_order%0d", j), 32'(glist[j]), 32'(j % 4));
            gcnt[glist[j]]++;
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("fair_count_lane%0d", i), 32'(gcnt[i] >= 9 && gcnt[i] <= 11), 32'd1);

        // reset while busy with three lanes full
        apply(1, 4'h0, 28'h0, 1, 0);
        apply(0, 4'hF, {4{7'h40}}, 1, 0);
        apply(0, 4'h0, 28'h0, 0, 0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_full", 32'(bus.in_ready), 32'h1);
        apply(1, 4'h0, 28'h0, 0, 0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'hF);
        check("rst_err_cnt", bus.err_cnt, 32'd0);
        apply(0, 4'hF, 28'($urandom), 1, 0);
        apply(0, 4'h0, 28'h0, 1, 0);
        check("post_rst_lane", 32'(bus.out_lane), 32'd0);

        // random traffic against the model
        for (int t = 0; t < 1500; t++)
            apply($urandom_range(0, 199) == 0, 4'($urandom), 28'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/hamm_lane_arbiter.md
# hamm_lane_arbiter

- Round-robin arbiter and sequencer that shares one downstream Hamming(7,4) correction channel between the four router lanes.
- Sits between the four lane transmit stages and a single shared corrector.
- Buffers one codeword per lane and grants the lanes fairly at up to one codeword per cycle.
- Tags each granted word with its lane, its 3-bit syndrome, and per-lane saturating error counters.

## Interface
Parameters:
- CNT_W, 8, width of each per-lane error counter (saturating)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_code  in  28  lane i codeword at [7i+6:7i]
- in_valid  in  4  lane i word present
- in_ready  out  4  lane i buffer empty; registered, equals ~full[i]
- out_code  out  7  granted codeword (registered)
- out_lane  out  2  lane index of out_code
- out_syn  out  3  syndrome of out_code, {s4,s2,s1}
- out_valid  out  1  output register holds a word
- out_ready  in  1  downstream corrector accepts
- clr_cnt  in  1  synchronous clear of all error counters
- err_cnt  out  4*CNT_W  lane i counter at [CNT_W*i +: CNT_W]

## Operation
- Codeword bit order: code[k] is Hamming position k+1, so parity is at code[0], code[1] and code[3].
- Syndrome bits:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - A non-zero syndrome means an error was detected.
- Per-lane holding register buf[i] with flag full[i]:
  - Loads on in_valid[i] & in_ready[i].
  - Clears when lane i is granted.
- Output register is "free" when !out_valid, or when out_valid & out_ready in the same cycle.
- Arbiter FSM, two states:
  - IDLE (out_valid=0): if any full[i], grant, then go to BUSY; else stay in IDLE.
  - BUSY (out_valid=1), on out_ready:
    - If any full[i], grant a new word (back-to-back) and stay in BUSY.
    - Otherwise go to IDLE.
  - BUSY, no out_ready: hold out_code, out_lane and out_syn stable; no grant.
- Grant selection:
  - Choose the first full lane searching from ptr+1 upward, mod 4.
  - On a grant: ptr <= granted lane; out_code <= buf; out_lane <= lane; out_syn <= syndrome(buf); full[lane] <= 0.
- Error counters:
  - On out_valid & out_ready with out_syn != 0, err_cnt[out_lane] increments.
  - Counters saturate at 2^CNT_W-1 (255 by default) and do not wrap.
  - clr_cnt takes priority over a same-cycle increment: the result is 0.
- A lane cannot load and be granted in the same cycle, because in_ready is low while full.

## Timing
- Reset values:
  - in_ready = 4'b1111
  - out_valid = 0
  - out_code, out_lane, out_syn = 0
  - err_cnt = 0
  - ptr = 3, so lane 0 wins first
  - FSM = IDLE
- Reset mid-operation drops all buffered and output words with no handshake; the FSM returns to IDLE.
- Latency: an input handshake at edge N sets full at N+1's cycle, and the word is granted at edge N+1. out_valid is therefore high in the cycle after that, i.e. two edges after the input handshake when idle.
- Aggregate throughput is 1 word/cycle while any lane is full and out_ready=1.
- Per-lane throughput is at most 1 word per 2 cycles.
- Fairness: with all lanes continuously full, grants go 0,1,2,3,0,…. No lane waits more than 3 grants.
- out_ready low for K cycles stalls the output and holds it stable; buffers stay full and in_ready stays low.
- Counter update is visible the cycle after the output handshake.

## Test plan
- Reset, then lane 0 sends 7'b1111111 with out_ready=1:
  - out_valid rises 2 edges later.
  - out_lane=0, out_syn=3'b000.
  - err_cnt lane 0 stays 0.
  - in_ready[0] is low for exactly 1 cycle.
- All four lanes load at the same edge (codes 7'h00, 7'h7F, 7'h04, 7'h40), out_ready=1:
  - Outputs appear on consecutive cycles with lanes 0,1,2,3.
  - Syndromes 0,0,3,7.
  - err_cnt = {lane3=1, lane2=1, lane1=0, lane0=0}.
- Hold out_ready=0 for 5 cycles with lanes 1 and 2 full:
  - out_code, out_lane and out_syn are stable throughout.
  - in_ready[2:1]=0 throughout.
  - Releasing out_ready drains the remaining word next.
- Lane 3 sends 7'h40 300 times:
  - err_cnt lane 3 saturates at 255.
  - Then assert clr_cnt in the same cycle as an erroneous handshake: the counter reads 0.
- Continuous traffic on all lanes for 40 cycles:
  - Grant order is strictly 0,1,2,3 repeating.
  - Each lane gets 10 grants ±1.
- Assert rst with out_valid=1 and 3 lanes full:
  - Next cycle: out_valid=0, in_ready=4'b1111, err_cnt=0.
  - First post-reset grant goes to lane 0.
